sync_fifo_level: RTL and testbench

SYNC_FIFO_LEVEL -- requirements
Module: sync_fifo_level

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo_level.sv | 130 +++++++++++++
 tb/tb_sync_fifo_level.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and the pointer-operation encoding for the level-tracking sync FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH    = 3;
  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_AEMPTY_THRESH = 1;
  localparam int MAX_ADDR_WIDTH        = 12;

  typedef enum logic [1:0] {
    NOP      = 2'b00,
    PUSH     = 2'b01,
    POP      = 2'b10,
    PUSH_POP = 2'b11
  } ptr_op_e;

  // Accepted write in bit 0, accepted read in bit 1.
  function automatic ptr_op_e decode_op(input logic push, input logic pop);
    return ptr_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH distributed RAM: synchronous write, asynchronous (show-ahead) read.
module sync_fifo_mem #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with registered occupancy level and almost-full/empty flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_level
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_addr_width
    $error("sync_fifo_level: ADDR_WIDTH %0d outside 1..%0d", ADDR_WIDTH, MAX_ADDR_WIDTH);
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_level: AFULL_THRESH %0d exceeds DEPTH %0d", AFULL_THRESH, DEPTH);
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
    $error("sync_fifo_level: AEMPTY_THRESH %0d must be below DEPTH %0d", AEMPTY_THRESH, DEPTH);
  end

  localparam logic [ADDR_WIDTH:0]   FULL_LVL   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   level_reg, level_next;
  logic                  wincr, rincr;
  ptr_op_e               op;

  // All status flags come from the registered level, never from the requests.
  assign wfull         = (level_reg == FULL_LVL);
  assign rempty        = (level_reg == '0);
  assign walmost_full  = (level_reg >= AFULL_LVL);
  assign ralmost_empty = (level_reg <= AEMPTY_LVL);
  assign level         = level_reg;

  assign wincr = wen & ~wfull;
  assign rincr = ren & ~rempty;
  assign op    = decode_op(wincr, rincr);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    unique case (op)
      PUSH: begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        level_next  = level_reg + LVL_ONE;
      end
      POP: begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
        level_next  = level_reg - LVL_ONE;
      end
      PUSH_POP: begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  sync_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wincr),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg, underflow_reg;

  // A rejected write while full only counts as overflow when no read frees a slot that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wen & wfull & ~rincr) begin
        overflow_reg <= 1'b1;
      end
      if (ren & rempty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level (ADDR_WIDTH=3, DATA_WIDTH=8, thresholds 6/1).
// Error-flag checks are included when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_level;

  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wfull, walmost_full, rempty, ralmost_empty;
  logic [DW-1:0] rdata;
  logic [AW:0]   level;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow, underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_level #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wen           (wen),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .ren           (ren),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow      (overflow),
    .underflow     (underflow),
`endif
    .level         (level)
  );

  // One clock of stimulus; the queue model follows the FIFO rules on the same edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    int sz;
    reset = r; wen = w; ren = rd; wdata = d;
    @(posedge clk);
    sz = model_q.size();
    if (r) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (w && sz == DEPTH && !rd) exp_ovf = 1'b1;
      if (rd && sz == 0) exp_udf = 1'b1;
      if (rd && sz > 0) void'(model_q.pop_front());
      if (w && sz < DEPTH) model_q.push_back(d);
    end
    #1;
    reset = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    n_checks++;
    if (level !== 4'd0 || rempty !== 1'b1 || ralmost_empty !== 1'b1 ||
        wfull !== 1'b0 || walmost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: level=%0d rempty=%b raempty=%b wfull=%b wafull=%b, expected 0 1 1 0 0",
               level, rempty, ralmost_empty, wfull, walmost_full);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err_flags: ovf=%b udf=%b, expected 0 0", overflow, underflow);
    end
`endif
  endtask

  task automatic test_fill_drain();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      n_checks++;
      if (level !== 4'(i) || walmost_full !== (i >= AFULL) || wfull !== (i == DEPTH) ||
          rempty !== 1'b0 || rdata !== 8'h01) begin
        n_fail++;
        $display("FAIL fill[%0d]: level=%0d wafull=%b wfull=%b rempty=%b rdata=%h, expected level=%0d wafull=%b wfull=%b rempty=0 rdata=01",
                 i, level, walmost_full, wfull, rempty, rdata, i, (i >= AFULL), (i == DEPTH));
      end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if (rdata !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: rdata=%h, expected %h", i, rdata, 8'(i));
      end
      step(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (level !== 4'(DEPTH - i) || ralmost_empty !== ((DEPTH - i) <= AEMPTY)) begin
        n_fail++;
        $display("FAIL drain_level[%0d]: level=%0d raempty=%b, expected level=%0d raempty=%b",
                 i, level, ralmost_empty, DEPTH - i, ((DEPTH - i) <= AEMPTY));
      end
    end
    n_checks++;
    if (rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: rempty=%b, expected 1", rempty);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [DW-1:0] exp_seq[DEPTH];
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h11 + 8'(i));
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    n_checks++;
    if (level !== 4'd7 || wfull !== 1'b0 || rdata !== 8'h12) begin
      n_fail++;
      $display("FAIL full_wr_rd: level=%0d wfull=%b rdata=%h, expected level=7 wfull=0 rdata=12",
               level, wfull, rdata);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wr_rd_ovf: ovf=%b, expected 0", overflow);
    end
`endif
    step(1'b0, 1'b1, 1'b0, 8'hBB);
    step(1'b0, 1'b1, 1'b0, 8'hCC);
    n_checks++;
    if (level !== 4'd8 || wfull !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject: level=%0d wfull=%b, expected level=8 wfull=1", level, wfull);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject_ovf: ovf=%b, expected 1", overflow);
    end
`endif
    for (int i = 0; i < DEPTH - 1; i++) exp_seq[i] = 8'h12 + 8'(i);
    exp_seq[DEPTH-1] = 8'hBB;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rdata !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: rdata=%h, expected %h", i, rdata, exp_seq[i]);
      end
      step(1'b0, 1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic test_empty_simultaneous();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h5C);
    n_checks++;
    if (level !== 4'd1 || rempty !== 1'b0 || rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL empty_wr_rd: level=%0d rempty=%b rdata=%h, expected level=1 rempty=0 rdata=5c",
               level, rempty, rdata);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (rempty !== 1'b1 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_after_pop: level=%0d rempty=%b, expected level=0 rempty=1", level, rempty);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_udf_sticky: udf=%b ovf=%b, expected udf=1 ovf=0", underflow, overflow);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wval, rval;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    wval = 8'hFA;
    rval = 8'hFA;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, wval);
      wval = wval + 8'd1;
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (rdata !== rval) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: rdata=%h, expected %h", i, rdata, rval);
      end
      step(1'b0, 1'b1, 1'b1, wval);
      wval = wval + 8'd1;
      rval = rval + 8'd1;
      n_checks++;
      if (level !== 4'd4) begin
        n_fail++;
        $display("FAIL b2b_level[%0d]: level=%0d, expected 4", i, level);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h40 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    n_checks++;
    if (level !== 4'd0 || rempty !== 1'b1 || ralmost_empty !== 1'b1 ||
        wfull !== 1'b0 || walmost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: level=%0d rempty=%b raempty=%b wfull=%b wafull=%b, expected 0 1 1 0 0",
               level, rempty, ralmost_empty, wfull, walmost_full);
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_err: ovf=%b udf=%b, expected 0 0", overflow, underflow);
    end
`endif
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    n_checks++;
    if (level !== 4'd1 || rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL reset_mid_restart: level=%0d rdata=%h, expected level=1 rdata=3c", level, rdata);
    end
  endtask

  task automatic test_random();
    logic [AW:0] exp_lvl;
    int sz, wbias;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      wbias = ((i / 50) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < wbias),
           ($urandom_range(0, 99) < (100 - wbias)),
           8'($urandom));
      sz = model_q.size();
      exp_lvl = (AW + 1)'(sz);
      n_checks++;
      if (level !== exp_lvl || rempty !== (sz == 0) || wfull !== (sz == DEPTH) ||
          walmost_full !== (sz >= AFULL) || ralmost_empty !== (sz <= AEMPTY)) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: level=%0d rempty=%b wfull=%b wafull=%b raempty=%b, expected level=%0d",
                 i, level, rempty, wfull, walmost_full, ralmost_empty, sz);
      end
      if (sz > 0) begin
        n_checks++;
        if (rdata !== model_q[0]) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: rdata=%h, expected %h", i, rdata, model_q[0]);
        end
      end
`ifdef SYNC_FIFO_ERR_EN
      n_checks++;
      if (overflow !== exp_ovf || underflow !== exp_udf) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: ovf=%b udf=%b, expected ovf=%b udf=%b",
                 i, overflow, underflow, exp_ovf, exp_udf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simultaneous();
    test_empty_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
